tow_match_ctrl: RTL and testbench
=================================

// Module: tow_match_ctrl
// PURPOSE
//  Master controller for multi-round Tug-of-War matches. Sequences wait, dark, play and gloat phases with
//  parametrised dwell times and keeps per-side round scores. Declares a match winner at ROUNDS_TO_WIN and
//  holds until a new match is requested. Sits between the slow-tick/random generators and the LED scorer.
// PARAMETERS
//  WAIT_TICKS     2  slowenable ticks spent in WAIT after reset/new match (>=1)
//  GLOAT_TICKS    2  slowenable ticks spent in GLOAT after each round win (>=1)
//  ROUNDS_TO_WIN  3  round wins needed to take the match (1..2**SCORE_W-1)
//  SCORE_W        3  width of each side's score counter
//  TICK_W         4  width of the dwell counter (must hold max(WAIT_TICKS,GLOAT_TICKS)-1)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        asynchronous, active-high reset
//  slowenable    in   1        one-cycle slow tick strobe
//  rout          in   1        random "go dark -> play" qualifier, sampled only with slowenable
//  winrnd        in   1        one-cycle round-won strobe from scorer
//  win_side      in   1        side that won the round, valid with winrnd (0=left, 1=right)
//  new_match     in   1        one-cycle request to start a new match, honoured only in MATCH_END
//  leds_on       out  1        LED enable
//  leds_ctrl     out  3        0 ALL_OFF, 1 ALL_ON, 2 RESET_CODE, 3 SCORE, 4 MATCH_WIN
//  clear         out  1        clear scorer position
//  score_l       out  SCORE_W  left-side rounds won
//  score_r       out  SCORE_W  right-side rounds won
//  match_over    out  1        high while in MATCH_END
//  match_winner  out  1        winning side; valid while match_over=1, else 0
// BEHAVIOUR
//  - State, dwell counter and scores are registers; all outputs are Moore-decoded from registered state/scores.
//  - Reset: state=RESET, tick_cnt=0, score_l=score_r=0, match_winner=0; outputs leds_on=1, clear=1, leds_ctrl=2, match_over=0.
//  - States / outputs (leds_on, clear, leds_ctrl):
//    RESET (1,1,2): next cycle -> WAIT unconditionally once rst low.
//    WAIT (1,1,1): count slowenable; on the WAIT_TICKS-th tick -> DARK. winrnd ignored.
//    DARK (0,0,0): winrnd -> GLOAT (priority); else slowenable&&rout -> PLAY; else stay.
//    PLAY (1,0,3): winrnd -> GLOAT; else stay.
//    GLOAT (1,1,3): count slowenable; on the GLOAT_TICKS-th tick -> MATCH_END if either score == ROUNDS_TO_WIN, else DARK.
//    MATCH_END (1,1,4): hold; new_match -> WAIT with score_l, score_r, match_winner cleared in the same edge.
//    Unused encodings -> RESET (outputs 0,1,2).
//  - tick_cnt clears on every state entry; exit on the slowenable tick with tick_cnt == TICKS-1.
//  - Score update: on the edge leaving DARK/PLAY due to winrnd, side win_side increments by 1, saturating at
//    ROUNDS_TO_WIN. Exactly one side increments per round. match_winner latched on the same edge if that
//    increment reaches ROUNDS_TO_WIN.
//  - winrnd outside DARK/PLAY: no score change, no transition. new_match outside MATCH_END: ignored.
//  - Simultaneous winrnd and slowenable&&rout in DARK: winrnd wins, score updates, no visit to PLAY.
//  - rst mid-operation (any state): immediate return to reset values, including scores.
//  - Latency: transitions occur on the clk edge sampling the qualifying input; outputs change the same edge.
//  - No combinational path from inputs to outputs.
// TESTING
//  1. Reset release, WAIT_TICKS=2: 2 slowenable pulses -> WAIT held, DARK entered on 2nd tick; leds_ctrl 2->1->0.
//  2. In DARK, slowenable=1, rout=1 -> PLAY (leds_ctrl=3, clear=0). Then winrnd with win_side=1 -> GLOAT; score_r 0->1.
//  3. DARK with winrnd=1, slowenable=1, rout=1 in the same cycle -> GLOAT, score updated, PLAY never entered.
//  4. ROUNDS_TO_WIN=3: left wins 3 rounds -> after 3rd GLOAT, MATCH_END; match_over=1, match_winner=0, leds_ctrl=4, score_l=3.
//  5. MATCH_END: winrnd pulses -> no change; new_match -> WAIT, scores 0, match_over=0.
//  6. Assert rst during PLAY with score_l=2 -> outputs (1,1,2), scores 0 immediately (async), WAIT next cycle after release.

Source files
------------

// File: rtl/tow_match_ctrl.sv
// ---------------------------------------------------------------------------
// tow_match_ctrl
// Master controller for multi-round Tug-of-War matches. It steps through the
// wait, dark, play and gloat phases, with parametrised dwell times, and keeps
// a round score for each side. When one side reaches ROUNDS_TO_WIN it declares
// that side the match winner and holds until a new match is requested.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   slowenable_i   in   one-cycle slow tick strobe
//   rout_i         in   random "go dark -> play" qualifier, used only with a tick
//   winrnd_i       in   one-cycle round-won strobe from the scorer
//   win_side_i     in   side that won the round (0=left, 1=right)
//   new_match_i    in   one-cycle new-match request, honoured only at match end
//   leds_on_o      out  LED enable
//   leds_ctrl_o    out  0 ALL_OFF, 1 ALL_ON, 2 RESET_CODE, 3 SCORE, 4 MATCH_WIN
//   clear_o        out  clear scorer position
//   score_l_o      out  left-side rounds won
//   score_r_o      out  right-side rounds won
//   match_over_o   out  high while the match-end state is held
//   match_winner_o out  winning side while match_over_o=1, else 0
// ---------------------------------------------------------------------------
module tow_match_ctrl #(
    parameter int WAIT_TICKS    = 2,
    parameter int GLOAT_TICKS   = 2,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int SCORE_W       = 3,
    parameter int TICK_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slowenable_i,
    input  logic               rout_i,
    input  logic               winrnd_i,
    input  logic               win_side_i,
    input  logic               new_match_i,
    output logic               leds_on_o,
    output logic [2:0]         leds_ctrl_o,
    output logic               clear_o,
    output logic [SCORE_W-1:0] score_l_o,
    output logic [SCORE_W-1:0] score_r_o,
    output logic               match_over_o,
    output logic               match_winner_o
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT      = 3'd1,
        S_DARK      = 3'd2,
        S_PLAY      = 3'd3,
        S_GLOAT     = 3'd4,
        S_MATCH_END = 3'd5
    } state_t;

    localparam logic [TICK_W-1:0]  WAIT_LAST  = TICK_W'(WAIT_TICKS - 1);
    localparam logic [TICK_W-1:0]  GLOAT_LAST = TICK_W'(GLOAT_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(ROUNDS_TO_WIN);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               winner_q, winner_d;

    logic [SCORE_W-1:0] score_l_inc;
    logic [SCORE_W-1:0] score_r_inc;
    logic               roundWon;

    assign score_l_inc = score_l_q + 1'b1;
    assign score_r_inc = score_r_q + 1'b1;

    // Registered state, dwell counter, scores and latched winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET;
            tick_q    <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
        end
    end

    // Next-state logic. The dwell counter is cleared on every state change so
    // each phase starts counting ticks from zero.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        roundWon  = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_WAIT;
                tick_d  = '0;
            end
            S_WAIT: begin
                if (slowenable_i) begin
                    if (tick_q == WAIT_LAST) begin
                        state_d = S_DARK;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DARK: begin
                // A round win takes priority over the go-to-play qualifier.
                if (winrnd_i) begin
                    roundWon = 1'b1;
                end else if (slowenable_i && rout_i) begin
                    state_d = S_PLAY;
                    tick_d  = '0;
                end
            end
            S_PLAY: begin
                if (winrnd_i) begin
                    roundWon = 1'b1;
                end
            end
            S_GLOAT: begin
                if (slowenable_i) begin
                    if (tick_q == GLOAT_LAST) begin
                        tick_d = '0;
                        if (score_l_q == WIN_SCORE || score_r_q == WIN_SCORE) begin
                            state_d = S_MATCH_END;
                        end else begin
                            state_d = S_DARK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_MATCH_END: begin
                if (new_match_i) begin
                    state_d   = S_WAIT;
                    tick_d    = '0;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_RESET;
                tick_d  = '0;
            end
        endcase

        // Credit exactly one side, saturating at the winning score; the
        // winner is latched on the increment that reaches it.
        if (roundWon) begin
            state_d = S_GLOAT;
            tick_d  = '0;
            if (win_side_i) begin
                if (score_r_q != WIN_SCORE) begin
                    score_r_d = score_r_inc;
                    if (score_r_inc == WIN_SCORE) begin
                        winner_d = 1'b1;
                    end
                end
            end else begin
                if (score_l_q != WIN_SCORE) begin
                    score_l_d = score_l_inc;
                    if (score_l_inc == WIN_SCORE) begin
                        winner_d = 1'b0;
                    end
                end
            end
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        leds_on_o   = 1'b0;
        clear_o     = 1'b1;
        leds_ctrl_o = 3'd2;
        case (state_q)
            S_RESET:     begin leds_on_o = 1'b1; clear_o = 1'b1; leds_ctrl_o = 3'd2; end
            S_WAIT:      begin leds_on_o = 1'b1; clear_o = 1'b1; leds_ctrl_o = 3'd1; end
            S_DARK:      begin leds_on_o = 1'b0; clear_o = 1'b0; leds_ctrl_o = 3'd0; end
            S_PLAY:      begin leds_on_o = 1'b1; clear_o = 1'b0; leds_ctrl_o = 3'd3; end
            S_GLOAT:     begin leds_on_o = 1'b1; clear_o = 1'b1; leds_ctrl_o = 3'd3; end
            S_MATCH_END: begin leds_on_o = 1'b1; clear_o = 1'b1; leds_ctrl_o = 3'd4; end
            default:     begin leds_on_o = 1'b0; clear_o = 1'b1; leds_ctrl_o = 3'd2; end
        endcase
    end

    assign score_l_o      = score_l_q;
    assign score_r_o      = score_r_q;
    assign match_over_o   = (state_q == S_MATCH_END);
    assign match_winner_o = (state_q == S_MATCH_END) && winner_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tow_match_ctrl
// Self-checking bench for tow_match_ctrl. A phase-level reference model tracks
// the match (phase, ticks seen in this phase, per-side scores, winner). The
// model's expected outputs are compared against the DUT on every falling edge.
// Directed scenarios pin the model with literal values, and a randomized run
// follows them.
// ---------------------------------------------------------------------------
module tb_tow_match_ctrl;

    localparam int WAIT_TICKS    = 2;
    localparam int GLOAT_TICKS   = 2;
    localparam int ROUNDS_TO_WIN = 3;
    localparam int SCORE_W       = 3;
    localparam int TICK_W        = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               slowenable = 1'b0;
    logic               rout = 1'b0;
    logic               winrnd = 1'b0;
    logic               win_side = 1'b0;
    logic               new_match = 1'b0;
    logic               leds_on;
    logic [2:0]         leds_ctrl;
    logic               clear;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               match_over;
    logic               match_winner;

    int testsRun    = 0;
    int testsFailed = 0;

    tow_match_ctrl #(
        .WAIT_TICKS   (WAIT_TICKS),
        .GLOAT_TICKS  (GLOAT_TICKS),
        .ROUNDS_TO_WIN(ROUNDS_TO_WIN),
        .SCORE_W      (SCORE_W),
        .TICK_W       (TICK_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .slowenable_i  (slowenable),
        .rout_i        (rout),
        .winrnd_i      (winrnd),
        .win_side_i    (win_side),
        .new_match_i   (new_match),
        .leds_on_o     (leds_on),
        .leds_ctrl_o   (leds_ctrl),
        .clear_o       (clear),
        .score_l_o     (score_l),
        .score_r_o     (score_r),
        .match_over_o  (match_over),
        .match_winner_o(match_winner)
    );

    always #5 clk = ~clk;

    // Reference model: the phases of a match and the outputs each one shows.
    localparam int P_RESET = 0, P_WAIT = 1, P_DARK = 2, P_PLAY = 3, P_GLOAT = 4, P_END = 5;
    int expOn[6]   = '{1, 1, 0, 1, 1, 1};
    int expClr[6]  = '{1, 1, 0, 0, 1, 1};
    int expCtrl[6] = '{2, 1, 0, 3, 3, 4};

    int mPhase    = P_RESET;
    int ticksSeen = 0;
    int mScore[2] = '{0, 0};
    int mWinner   = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Advance the model on every clock edge; reset returns everything to zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase    = P_RESET;
            ticksSeen = 0;
            mScore    = '{0, 0};
            mWinner   = 0;
        end else begin
            case (mPhase)
                P_RESET: begin
                    mPhase    = P_WAIT;
                    ticksSeen = 0;
                end
                P_WAIT: begin
                    if (slowenable) begin
                        ticksSeen++;
                        if (ticksSeen == WAIT_TICKS) begin
                            mPhase    = P_DARK;
                            ticksSeen = 0;
                        end
                    end
                end
                P_DARK, P_PLAY: begin
                    if (winrnd) begin
                        if (mScore[win_side] < ROUNDS_TO_WIN) begin
                            mScore[win_side]++;
                            if (mScore[win_side] == ROUNDS_TO_WIN) mWinner = int'(win_side);
                        end
                        mPhase    = P_GLOAT;
                        ticksSeen = 0;
                    end else if (mPhase == P_DARK && slowenable && rout) begin
                        mPhase    = P_PLAY;
                        ticksSeen = 0;
                    end
                end
                P_GLOAT: begin
                    if (slowenable) begin
                        ticksSeen++;
                        if (ticksSeen == GLOAT_TICKS) begin
                            ticksSeen = 0;
                            if (mScore[0] == ROUNDS_TO_WIN || mScore[1] == ROUNDS_TO_WIN) mPhase = P_END;
                            else mPhase = P_DARK;
                        end
                    end
                end
                default: begin
                    if (new_match) begin
                        mPhase    = P_WAIT;
                        ticksSeen = 0;
                        mScore    = '{0, 0};
                        mWinner   = 0;
                    end
                end
            endcase
        end
    end

    // Compare every output against the model once per cycle, away from the edge.
    always @(negedge clk) begin
        checkOutput("leds_on", int'(leds_on), expOn[mPhase]);
        checkOutput("clear", int'(clear), expClr[mPhase]);
        checkOutput("leds_ctrl", int'(leds_ctrl), expCtrl[mPhase]);
        checkOutput("score_l", int'(score_l), mScore[0]);
        checkOutput("score_r", int'(score_r), mScore[1]);
        checkOutput("match_over", int'(match_over), (mPhase == P_END) ? 1 : 0);
        checkOutput("match_winner", int'(match_winner), (mPhase == P_END) ? mWinner : 0);
    end

    // Drive one cycle of inputs, let one rising edge consume them, then idle.
    task automatic applyStimulus(input logic se, input logic ro, input logic wr,
                                 input logic ws, input logic nm);
        slowenable = se;
        rout       = ro;
        winrnd     = wr;
        win_side   = ws;
        new_match  = nm;
        @(posedge clk);
        #2;
        slowenable = 1'b0;
        rout       = 1'b0;
        winrnd     = 1'b0;
        win_side   = 1'b0;
        new_match  = 1'b0;
    endtask

    // Dwell through GLOAT with two ticks.
    task automatic gloatOut();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("lit reset leds_ctrl", int'(leds_ctrl), 2);
        checkOutput("lit reset clear", int'(clear), 1);
        rst = 1'b0;

        // Reset release, WAIT dwell of two ticks, then DARK.
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("lit wait leds_ctrl", int'(leds_ctrl), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lit wait held", int'(leds_ctrl), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lit dark leds_ctrl", int'(leds_ctrl), 0);
        checkOutput("lit dark leds_on", int'(leds_on), 0);

        // DARK -> PLAY, then a right-side round win.
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("lit play leds_ctrl", int'(leds_ctrl), 3);
        checkOutput("lit play clear", int'(clear), 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("lit gloat clear", int'(clear), 1);
        checkOutput("lit score_r one", int'(score_r), 1);
        gloatOut();

        // Round win and play qualifier together in DARK: straight to GLOAT.
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("lit priority clear", int'(clear), 1);
        checkOutput("lit priority score_l", int'(score_l), 1);
        gloatOut();
        applyStimulus(0, 0, 1, 0, 0);
        gloatOut();
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("lit score_l three", int'(score_l), 3);
        checkOutput("lit not over in gloat", int'(match_over), 0);
        gloatOut();
        checkOutput("lit match_end leds_ctrl", int'(leds_ctrl), 4);
        checkOutput("lit match_over", int'(match_over), 1);
        checkOutput("lit match_winner left", int'(match_winner), 0);

        // Round wins are ignored at match end; new_match restarts.
        applyStimulus(1, 1, 1, 1, 0);
        checkOutput("lit ignored score_r", int'(score_r), 1);
        checkOutput("lit ignored leds_ctrl", int'(leds_ctrl), 4);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("lit new match leds_ctrl", int'(leds_ctrl), 1);
        checkOutput("lit new match score_l", int'(score_l), 0);
        checkOutput("lit new match over", int'(match_over), 0);

        // Build score_l=2 and enter PLAY, then reset asynchronously.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        gloatOut();
        applyStimulus(0, 0, 1, 0, 0);
        gloatOut();
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("lit play before rst", int'(score_l), 2);
        rst = 1'b1;
        #1;
        checkOutput("lit async rst leds_ctrl", int'(leds_ctrl), 2);
        checkOutput("lit async rst score_l", int'(score_l), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("lit wait after rst", int'(leds_ctrl), 1);

        // A right-side match to pin the winner flag.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int r = 0; r < ROUNDS_TO_WIN; r++) begin
            applyStimulus(0, 0, 1, 1, 0);
            gloatOut();
        end
        checkOutput("lit match_winner right", int'(match_winner), 1);
        checkOutput("lit score_r three", int'(score_r), 3);
        applyStimulus(0, 0, 0, 0, 1);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #1 rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 3) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
